circle_intersect_stream: RTL and testbench

Streaming, handshaked circle–circle intersection engine for the trilateration datapath. It accepts two circles (centre plus radius) per transaction, flags degenerate, tangent and non-intersecting geometry, and computes both intersection points. The integer square root is sequential, one result bit per cycle, and both ends are valid/ready. It sits between the anchor/range front end and the position solver, and replaces the free-running single-shot intersection stage.

---
 rtl/circle_intersect_pkg.sv | 53 +++++
 rtl/circle_intersect_stream_isqrt.sv | 60 ++++++
 rtl/circle_intersect_stream.sv | 194 +++++++++++++++++++
 tb/tb_circle_intersect_stream.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/circle_intersect_pkg.sv
// circle_intersect_pkg
// Shared types and helpers for the circle intersection engine:
//   - state_e      : control FSM states
//   - circle_t     : unpacked circle {x, y, r}, sign-extended to MaxN/MaxN+1 bits
//   - *_of(n)      : derived widths for coordinate width n
//   - unpack_circle: split a packed {x[n-1:0], y[n-1:0], r[n:0]} word into circle_t
package circle_intersect_pkg;

    // Largest coordinate width the unpack helper supports.
    localparam int unsigned MaxN  = 16;
    localparam int unsigned PackW = 3 * MaxN + 1;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StSqrt,
        StSolve,
        StHold
    } state_e;

    typedef struct packed {
        logic signed [MaxN-1:0] x;
        logic signed [MaxN-1:0] y;
        logic signed [MaxN:0]   r;
    } circle_t;

    function automatic int unsigned xw_of(input int unsigned n);
        return 4 * n + 10;
    endfunction

    function automatic int unsigned yw_of(input int unsigned n);
        return 3 * n + 7;
    endfunction

    function automatic int unsigned wsqr_w_of(input int unsigned n);
        return 6 * n + 14;
    endfunction

    function automatic int unsigned root_w_of(input int unsigned n);
        return 3 * n + 7;
    endfunction

    // Each field is shifted up to the MSB and arithmetically shifted back down,
    // which sign-extends it without any variable bit indexing.
    function automatic circle_t unpack_circle(input logic [PackW-1:0] v, input int unsigned n);
        circle_t c;
        c.x = MaxN'($signed(v << (PackW - 1 - 3 * n)) >>> (PackW - n));
        c.y = MaxN'($signed(v << (PackW - 1 - 2 * n)) >>> (PackW - n));
        c.r = (MaxN + 1)'($signed(v << (PackW - 1 - n)) >>> (PackW - n - 1));
        return c;
    endfunction

endpackage

// File: rtl/circle_intersect_stream_isqrt.sv
// isqrt_seq
// Sequential restoring integer square root, one result bit per cycle, MSB first.
//   clk   : clock
//   rst   : synchronous active-low reset, clears all state
//   start : load A and begin; takes OW cycles after the load edge
//   A     : radicand (IW bits, unsigned, IW == 2*OW)
//   O     : root, floor(sqrt(A)), valid after the edge on which done is high
//   done  : high during the final iteration cycle
module isqrt_seq #(
    parameter int unsigned IW = 62,
    parameter int unsigned OW = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] A,
    output logic [OW-1:0] O,
    output logic          done
);
    localparam int unsigned CW = $clog2(OW + 1);

    logic [IW-1:0] rad_q;
    logic [OW+1:0] rem_q;
    logic [OW-1:0] root_q;
    logic [CW-1:0] cnt_q;

    logic [OW+3:0] rem_sh;
    logic [OW+3:0] trial;
    logic [OW+3:0] rem_sub;
    logic          take;

    always_comb begin
        rem_sh  = {rem_q, rad_q[IW-1 -: 2]};
        trial   = {2'b00, root_q, 2'b01};
        take    = (rem_sh >= trial);
        rem_sub = take ? (rem_sh - trial) : rem_sh;
        done    = (cnt_q == CW'(1));
        O       = root_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            rad_q  <= A;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= CW'(OW);
        end else if (cnt_q != '0) begin
            rad_q  <= rad_q << 2;
            rem_q  <= (OW + 2)'(rem_sub);
            root_q <= {root_q[OW-2:0], take};
            cnt_q  <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/circle_intersect_stream.sv
// circle_intersect_stream
// Handshaked circle-circle intersection: captures circles B and C, computes the
// discriminant w_sqr, takes its root sequentially and solves both points.
//   clk, rst            : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake (ready only in IDLE)
//   g_input, e_input    : circles B and C, packed {x[N-1:0], y[N-1:0], r[N:0]}
//   out_valid/out_ready : output handshake (valid only in HOLD)
//   x1, y1, x2, y2      : intersection points (point 1 uses +w)
//   nohit, tangent, degen : geometry flags
module circle_intersect_stream
    import circle_intersect_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned XW = xw_of(N),
    localparam int unsigned YW = yw_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3*N:0]  g_input,
    input  logic [3*N:0]  e_input,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] x1,
    output logic [XW-1:0] x2,
    output logic [YW-1:0] y1,
    output logic [YW-1:0] y2,
    output logic          nohit,
    output logic          tangent,
    output logic          degen
);
    localparam int unsigned WSW = wsqr_w_of(N);
    localparam int unsigned RW  = root_w_of(N);

    // All arithmetic runs at the w_sqr width; results that fit are exact.
    typedef logic signed [WSW-1:0] wide_t;

    state_e  state_q, state_d;
    logic    phase_q;
    circle_t b_q, c_q;
    wide_t   p_q, q_q, t_q;
    wide_t   ys1_q, ys2_q;
    logic    f_degen_q, f_nohit_q, f_tangent_q;

    logic          sq_start;
    logic          sq_done;
    logic [RW-1:0] sq_root;

    // Discriminant from the captured circles.
    wide_t xb, yb, rb, xc, yc, rc;
    wide_t p, q, t, pp, s, u, den, w_sqr;
    logic  calc_degen, calc_nohit, calc_tangent;

    always_comb begin
        xb = wide_t'(b_q.x);
        yb = wide_t'(b_q.y);
        rb = wide_t'(b_q.r);
        xc = wide_t'(c_q.x);
        yc = wide_t'(c_q.y);
        rc = wide_t'(c_q.r);
        p  = xc - xb;
        q  = yb - yc;
        t  = rb * rb - rc * rc + xc * xc - xb * xb + yc * yc - yb * yb;
        pp = p * p;
        s  = ((pp * yb * yb + pp * xb * xb - pp * rb * rb - p * t * xb) <<< 2) + t * t;
        u  = q * t - ((yb * pp) <<< 1) - ((p * q * xb) <<< 1);
        den   = pp + q * q;
        w_sqr = u * u - s * den;
        calc_degen   = (p == '0);
        calc_nohit   = !calc_degen && w_sqr[WSW-1];
        calc_tangent = !calc_degen && (w_sqr == '0);
    end

    // Point solve: y quotients in the first SOLVE cycle, x in the second.
    wide_t w, y_base, y1n, y2n, y_div, x_div, x1n, x2n;

    always_comb begin
        w      = wide_t'(sq_root);
        // Divisors forced to 1 when degenerate; the results are discarded then.
        y_div  = f_degen_q ? wide_t'(1) : (p_q * p_q + q_q * q_q);
        x_div  = f_degen_q ? wide_t'(1) : (p_q <<< 1);
        y_base = p_q * q_q * xb + yb * p_q * p_q - ((q_q * t_q) >>> 1);
        y1n    = y_base + (w >>> 1);
        y2n    = y_base - (w >>> 1);
        x1n    = (((ys1_q * q_q) <<< 1) + t_q) / x_div;
        x2n    = (((ys2_q * q_q) <<< 1) + t_q) / x_div;
    end

    isqrt_seq #(
        .IW(WSW),
        .OW(RW)
    ) u_isqrt (
        .clk  (clk),
        .rst  (rst),
        .start(sq_start),
        .A    (w_sqr),
        .O    (sq_root),
        .done (sq_done)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sq_start  = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StCalc;
            end
            StCalc: begin
                if (calc_degen || calc_nohit) begin
                    state_d = StSolve;
                end else begin
                    sq_start = 1'b1;
                    state_d  = StSqrt;
                end
            end
            StSqrt: begin
                if (sq_done) state_d = StSolve;
            end
            StSolve: begin
                if (phase_q) state_d = StHold;
            end
            StHold: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            phase_q     <= 1'b0;
            b_q         <= '0;
            c_q         <= '0;
            p_q         <= '0;
            q_q         <= '0;
            t_q         <= '0;
            ys1_q       <= '0;
            ys2_q       <= '0;
            f_degen_q   <= 1'b0;
            f_nohit_q   <= 1'b0;
            f_tangent_q <= 1'b0;
            x1          <= '0;
            x2          <= '0;
            y1          <= '0;
            y2          <= '0;
            nohit       <= 1'b0;
            tangent     <= 1'b0;
            degen       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && in_valid) begin
                b_q <= unpack_circle(PackW'(g_input), N);
                c_q <= unpack_circle(PackW'(e_input), N);
            end
            if (state_q == StCalc) begin
                p_q         <= p;
                q_q         <= q;
                t_q         <= t;
                f_degen_q   <= calc_degen;
                f_nohit_q   <= calc_nohit;
                f_tangent_q <= calc_tangent;
            end
            if (state_q == StSolve) begin
                phase_q <= !phase_q;
                if (!phase_q) begin
                    ys1_q <= y1n / y_div;
                    ys2_q <= y2n / y_div;
                end else begin
                    nohit   <= f_nohit_q;
                    tangent <= f_tangent_q;
                    degen   <= f_degen_q;
                    if (f_degen_q || f_nohit_q) begin
                        x1 <= '0;
                        x2 <= '0;
                        y1 <= '0;
                        y2 <= '0;
                    end else begin
                        x1 <= XW'(x1n);
                        y1 <= YW'(ys1_q);
                        x2 <= f_tangent_q ? XW'(x1n) : XW'(x2n);
                        y2 <= f_tangent_q ? YW'(ys1_q) : YW'(ys2_q);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_circle_intersect_stream.sv
// tb_circle_intersect_stream
// Directed, table-driven bench for circle_intersect_stream (N = 8), plus
// hand-written sequences for backpressure, back-to-back and mid-flight reset.
module tb_circle_intersect_stream;
    localparam int N  = 8;
    localparam int GW = 3 * N + 1;
    localparam int XW = 4 * N + 10;
    localparam int YW = 3 * N + 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [GW-1:0] g_input, e_input;
    logic [XW-1:0] x1, x2;
    logic [YW-1:0] y1, y2;
    logic          nohit, tangent, degen;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    circle_intersect_stream #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .g_input  (g_input),
        .e_input  (e_input),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x1       (x1),
        .x2       (x2),
        .y1       (y1),
        .y2       (y2),
        .nohit    (nohit),
        .tangent  (tangent),
        .degen    (degen)
    );

    typedef struct {
        int bx, by, br, cx, cy, cr;
        int ex1, ex2, ey1, ey2;
        int enohit, etan, edeg;
        int lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [GW-1:0] pack(input int x, input int y, input int r);
        return {N'(x), N'(y), (N + 1)'(r)};
    endfunction

    // Starts #1 after a posedge; captures on the next posedge.
    task automatic run_txn(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, longint'(in_ready), 1);
        g_input  = pack(v.bx, v.by, v.br);
        e_input  = pack(v.cx, v.cy, v.cr);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        g_input  = GW'($urandom);
        e_input  = GW'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_busy"}, longint'(in_ready), 0);
        check({tag, "_x1"}, longint'($signed(x1)), v.ex1);
        check({tag, "_x2"}, longint'($signed(x2)), v.ex2);
        check({tag, "_y1"}, longint'($signed(y1)), v.ey1);
        check({tag, "_y2"}, longint'($signed(y2)), v.ey2);
        check({tag, "_nohit"}, longint'(nohit), v.enohit);
        check({tag, "_tangent"}, longint'(tangent), v.etan);
        check({tag, "_degen"}, longint'(degen), v.edeg);
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_valid_drop"}, longint'(out_valid), 0);
            check({tag, "_ready_back"}, longint'(in_ready), 1);
        end
    endtask

    initial begin
        //           bx  by br  cx cy cr   x1  x2  y1  y2  nh tg dg lat
        vecs[0] = '{ 0,  0, 5,  6, 0, 5,   3,  3,  4, -4, 0, 0, 0, 34};
        vecs[1] = '{ 0,  0, 3,  6, 0, 3,   3,  3,  0,  0, 0, 1, 0, 34};
        vecs[2] = '{ 0,  0, 2, 10, 0, 2,   0,  0,  0,  0, 1, 0, 0,  3};
        vecs[3] = '{ 0,  0, 5,  0, 6, 5,   0,  0,  0,  0, 0, 0, 1,  3};
        vecs[4] = '{ 1,  1, 5,  7, 1, 5,   4,  4,  5, -3, 0, 0, 0, 34};
        vecs[5] = '{ 0,  0, 5,  1, 7, 5,  -3,  4,  4,  3, 0, 0, 0, 34};
        vecs[6] = '{ 0,  0, 5, -6, 0, 5,  -3, -3,  4, -4, 0, 0, 0, 34};
        vecs[7] = '{ 0,  0, 5,  6, 0, 4,   3,  3,  3, -3, 0, 0, 0, 34};

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        g_input   = '0;
        e_input   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_x1", longint'($signed(x1)), 0);
        check("rst_y2", longint'($signed(y2)), 0);
        check("rst_flags", longint'({nohit, tangent, degen}), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: result held for 10 cycles with out_ready low.
        out_ready = 1'b0;
        run_txn(vecs[0], "bp");
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", longint'(out_valid), 1);
            check("bp_hold_x1", longint'($signed(x1)), 3);
            check("bp_hold_y2", longint'($signed(y2)), -4);
            check("bp_hold_in_ready", longint'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", longint'(out_valid), 0);
        check("bp_release_in_ready", longint'(in_ready), 1);
        check("bp_keep_x1", longint'($signed(x1)), 3);
        check("bp_keep_y1", longint'($signed(y1)), 4);
        // Next transaction captured one edge after the handshake.
        run_txn(vecs[1], "b2b");

        // Reset at E0+15 aborts the in-flight root.
        @(negedge clk);
        g_input  = pack(0, 0, 5);
        e_input  = pack(6, 0, 5);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("midrst_busy", longint'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", longint'(in_ready), 1);
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_x1", longint'($signed(x1)), 0);
        check("midrst_x2", longint'($signed(x2)), 0);
        check("midrst_tangent", longint'(tangent), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_txn(vecs[0], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
